// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-slave/RAM subsystem: FSM state encoding,
// frame opcodes and default widths.
package spi_ram_pkg;

   localparam int DEF_FRAME_W = 10;
   localparam int DEF_DATA_W  = 8;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_CHK_CMD   = 3'd1;
   localparam logic [2:0] S_WRITE     = 3'd2;
   localparam logic [2:0] S_READ_ADD  = 3'd3;
   localparam logic [2:0] S_READ_DATA = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = S_IDLE,
      ST_CHK_CMD   = S_CHK_CMD,
      ST_WRITE     = S_WRITE,
      ST_READ_ADD  = S_READ_ADD,
      ST_READ_DATA = S_READ_DATA
   } state_t;

   localparam logic [1:0] OPC_WR_ADDR = 2'd0;
   localparam logic [1:0] OPC_WR_DATA = 2'd1;
   localparam logic [1:0] OPC_RD_ADDR = 2'd2;
   localparam logic [1:0] OPC_RD_DATA = 2'd3;

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first serialiser for the read byte: a load drives the MSB at once,
// the remaining bits follow one per clock, then the line returns to 0.
module spi_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_abort,
   output logic              o_miso,
   output logic              o_busy
);

   localparam logic [2:0] LAST_CNT = 3'(DATA_W - 1);

   logic [DATA_W-1:0] r_sr;
   logic [2:0]        r_cnt;
   logic              r_miso;
   logic              r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr   <= '0;
         r_cnt  <= '0;
         r_miso <= 1'b0;
         r_busy <= 1'b0;
      end else if (i_abort) begin
         r_cnt  <= '0;
         r_miso <= 1'b0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         r_sr   <= i_data;
         r_cnt  <= '0;
         r_miso <= i_data[DATA_W-1];
         r_busy <= 1'b1;
      end else if (r_busy) begin
         // r_cnt counts bits already placed after the MSB
         if (r_cnt == LAST_CNT) begin
            r_miso <= 1'b0;
            r_busy <= 1'b0;
         end else begin
            r_sr   <= {r_sr[DATA_W-2:0], 1'b0};
            r_miso <= r_sr[DATA_W-2];
            r_cnt  <= r_cnt + 3'd1;
         end
      end
   end

   assign o_miso = r_miso;
   assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames for the RAM and
// serialises the RAM's read byte back on MISO during read-data frames.
module spi_slave_if
   import spi_ram_pkg::*;
#(
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);
   localparam logic [3:0] CNT_FULL = 4'(FRAME_W);

   state_t             r_state;
   state_t             w_state_next;
   logic [FRAME_W-2:0] r_rx_shift;
   logic [FRAME_W-1:0] r_rx_data;
   logic               r_rx_valid;
   logic               r_rd_addr_done;
   logic [3:0]         r_bit_cnt;
   logic               r_tx_loaded;
   logic [FRAME_W-1:0] w_word;
   logic               w_in_frame;
   logic               w_frame_done;
   logic               w_tx_load;
   logic               w_tx_busy;

   assign w_word       = {r_rx_shift, MOSI};
   assign w_in_frame   = !SS_n && (r_state inside {ST_WRITE, ST_READ_ADD, ST_READ_DATA});
   assign w_frame_done = w_in_frame && (r_bit_cnt == LAST_BIT);
   // Only one RAM response is accepted per read-data frame, after the word has gone out
   assign w_tx_load    = !SS_n && (r_state == ST_READ_DATA) && (r_bit_cnt == CNT_FULL)
                         && tx_valid && !r_tx_loaded && !w_tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (SS_n) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    w_state_next = ST_CHK_CMD;
            ST_CHK_CMD: begin
               if (!MOSI)               w_state_next = ST_WRITE;
               else if (r_rd_addr_done) w_state_next = ST_READ_DATA;
               else                     w_state_next = ST_READ_ADD;
            end
            default:    w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_shift     <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_rd_addr_done <= 1'b0;
         r_bit_cnt      <= '0;
         r_tx_loaded    <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (SS_n) begin
            r_bit_cnt   <= '0;
            r_tx_loaded <= 1'b0;
         end else if (r_state == ST_CHK_CMD) begin
            r_rx_shift <= w_word[FRAME_W-2:0];
            r_bit_cnt  <= 4'd1;
         end else if (w_in_frame) begin
            if (r_bit_cnt < CNT_FULL) begin
               r_rx_shift <= w_word[FRAME_W-2:0];
               r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
            if (w_frame_done) begin
               r_rx_data  <= w_word;
               r_rx_valid <= 1'b1;
               if (w_word[FRAME_W-1 -: 2] == OPC_RD_ADDR)      r_rd_addr_done <= 1'b1;
               else if (w_word[FRAME_W-1 -: 2] == OPC_RD_DATA) r_rd_addr_done <= 1'b0;
            end
            if (w_tx_load) r_tx_loaded <= 1'b1;
         end
      end
   end

   spi_tx_shifter #(
      .DATA_W (DATA_W)
   ) u_tx_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tx_load),
      .i_data  (tx_data),
      .i_abort (SS_n),
      .o_miso  (MISO),
      .o_busy  (w_tx_busy)
   );

   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule
